vend_controller: RTL

- Parametrised vending-machine controller. Replaces the flat coin-counter/buy/refund arrangement with one clocked FSM.
- Accepts quarter/dime/nickel pulses into a capped credit register and sells any of NUM_ITEMS items with per-item prices.
- Dispenses change as a timed sequence of single-coin pulses.
- Credit and change counts feed the existing sevenseg display path.

---
 rtl/vend_controller.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/vend_controller.sv
// Vending-machine controller: capped coin credit, priced item sale,
// and greedy single-coin change dispensing driven by one FSM.
module vend_controller #(
    parameter int NUM_ITEMS   = 4,
    parameter int CREDIT_W    = 8,
    parameter int BASE_PRICE  = 35,
    parameter int PRICE_STEP  = 10,
    parameter int MAX_CREDIT  = 195,
    parameter int VEND_CYCLES = 2
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Quarters,
    input  logic                 Dimes,
    input  logic                 Nickles,
    input  logic [NUM_ITEMS-1:0] Buy,
    input  logic                 Refund,
    output logic [CREDIT_W-1:0]  Credit,
    output logic [NUM_ITEMS-1:0] Vending,
    output logic                 QuarterOut,
    output logic                 DimeOut,
    output logic                 NickelOut,
    output logic [3:0]           QuarterCnt,
    output logic [3:0]           DimeCnt,
    output logic [3:0]           NickelCnt,
    output logic                 CoinReject,
    output logic                 BuyDenied,
    output logic                 Busy
);

    localparam int SW = CREDIT_W + 1;
    localparam int VW = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic [NUM_ITEMS-1:0]  vend_q, vend_d;
    logic                  qo_q, qo_d;
    logic                  do_q, do_d;
    logic                  no_q, no_d;
    logic [3:0]            qc_q, qc_d;
    logic [3:0]            dc_q, dc_d;
    logic [3:0]            nc_q, nc_d;
    logic                  rej_q, rej_d;
    logic                  den_q, den_d;
    logic [VW-1:0]         vcnt_q, vcnt_d;

    logic [SW-1:0]         coin_sum;
    logic [SW-1:0]         cap_sum;
    logic                  any_coin;
    logic [NUM_ITEMS-1:0]  sel_oh;
    logic [31:0]           sel_price;

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c == 4'd15) ? c : c + 4'd1;
    endfunction

    always_comb begin
        coin_sum = (Quarters ? SW'(25) : SW'(0))
                 + (Dimes    ? SW'(10) : SW'(0))
                 + (Nickles  ? SW'(5)  : SW'(0));
        cap_sum  = {1'b0, credit_q} + coin_sum;
        any_coin = Quarters | Dimes | Nickles;
    end

    // Walk downward so the lowest asserted request wins.
    always_comb begin
        sel_oh    = '0;
        sel_price = '0;
        for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
            if (Buy[i]) begin
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
                sel_price = 32'(BASE_PRICE + i * PRICE_STEP);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        vend_d   = vend_q;
        qo_d     = 1'b0;
        do_d     = 1'b0;
        no_d     = 1'b0;
        qc_d     = qc_q;
        dc_d     = dc_q;
        nc_d     = nc_q;
        rej_d    = 1'b0;
        den_d    = 1'b0;
        vcnt_d   = vcnt_q;
        case (state_q)
            IDLE: begin
                if (|Buy) begin
                    rej_d = any_coin;
                    if (32'(credit_q) >= sel_price) begin
                        credit_d = credit_q - CREDIT_W'(sel_price);
                        vend_d   = sel_oh;
                        vcnt_d   = VW'(VEND_CYCLES - 1);
                        state_d  = VEND;
                    end else begin
                        den_d = 1'b1;
                    end
                end else if (Refund) begin
                    rej_d = any_coin;
                    if (credit_q != '0) begin
                        state_d = CHANGE;
                        qc_d    = '0;
                        dc_d    = '0;
                        nc_d    = '0;
                    end
                end else if (any_coin) begin
                    if (cap_sum <= SW'(MAX_CREDIT))
                        credit_d = cap_sum[CREDIT_W-1:0];
                    else
                        rej_d = 1'b1;
                end
            end
            VEND: begin
                rej_d = any_coin;
                if (vcnt_q == '0) begin
                    vend_d = '0;
                    if (credit_q != '0) begin
                        state_d = CHANGE;
                        qc_d    = '0;
                        dc_d    = '0;
                        nc_d    = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    vcnt_d = vcnt_q - VW'(1);
                end
            end
            CHANGE: begin
                rej_d = any_coin;
                if (credit_q >= CREDIT_W'(25)) begin
                    credit_d = credit_q - CREDIT_W'(25);
                    qo_d     = 1'b1;
                    qc_d     = sat_inc(qc_q);
                end else if (credit_q >= CREDIT_W'(10)) begin
                    credit_d = credit_q - CREDIT_W'(10);
                    do_d     = 1'b1;
                    dc_d     = sat_inc(dc_q);
                end else if (credit_q >= CREDIT_W'(5)) begin
                    credit_d = credit_q - CREDIT_W'(5);
                    no_d     = 1'b1;
                    nc_d     = sat_inc(nc_q);
                end
                if (credit_d == '0)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            credit_q <= '0;
            vend_q   <= '0;
            qo_q     <= 1'b0;
            do_q     <= 1'b0;
            no_q     <= 1'b0;
            qc_q     <= '0;
            dc_q     <= '0;
            nc_q     <= '0;
            rej_q    <= 1'b0;
            den_q    <= 1'b0;
            vcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            vend_q   <= vend_d;
            qo_q     <= qo_d;
            do_q     <= do_d;
            no_q     <= no_d;
            qc_q     <= qc_d;
            dc_q     <= dc_d;
            nc_q     <= nc_d;
            rej_q    <= rej_d;
            den_q    <= den_d;
            vcnt_q   <= vcnt_d;
        end
    end

    assign Credit     = credit_q;
    assign Vending    = vend_q;
    assign QuarterOut = qo_q;
    assign DimeOut    = do_q;
    assign NickelOut  = no_q;
    assign QuarterCnt = qc_q;
    assign DimeCnt    = dc_q;
    assign NickelCnt  = nc_q;
    assign CoinReject = rej_q;
    assign BuyDenied  = den_q;
    assign Busy       = (state_q != IDLE);

endmodule
